// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: fetch FSM state encoding and instruction size.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit_pc.sv
// Program counter for the fetch stage: sequential increment, redirect
// handling and the kill flag for redirects that arrive while a memory
// transaction is in flight.
module fetch_pc
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,        // instruction consumed: PC += 4
    input  logic            redirect,       // redirect pulse from execute
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            defer,          // request in flight (REQ or WAIT)
    input  logic            complete,       // in-flight response arriving this cycle
    output logic [XLEN-1:0] pc,
    output logic            kill
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            kill_q, kill_d;

    // Next PC / pending target / kill; a redirect landing on the completing
    // response is newest and wins over the stored pending target.
    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        kill_d = kill_q;
        if (complete && (kill_q || redirect)) begin
            pc_d   = redirect ? redirect_addr : pend_q;
            kill_d = 1'b0;
        end else if (redirect && defer) begin
            pend_d = redirect_addr;
            kill_d = 1'b1;
        end else if (redirect) begin
            pc_d = redirect_addr;
        end else if (advance) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
    end

    // PC, pending redirect target and kill flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_VECTOR;
            pend_q <= '0;
            kill_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            kill_q <= kill_d;
        end
    end

    assign pc   = pc_q;
    assign kill = kill_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: takes a fetch command, issues one read at PC,
// captures the response and presents it until consumed or redirected.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_fetch_valid,
    output logic            o_fetch_ready,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [XLEN-1:0] o_instr_data,
    output logic [XLEN-1:0] o_instr_pc,
    output logic            o_instr_fault,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    input  logic            i_imem_rsp_err,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_addr
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            fault_q, fault_d;
    logic            advance;
    logic            kill;
    logic [XLEN-1:0] pc;

    fetch_pc #(
        .RESET_VECTOR (RESET_VECTOR),
        .XLEN         (XLEN)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .advance       (advance),
        .redirect      (i_redirect_valid),
        .redirect_addr (i_redirect_addr),
        .defer         ((state_q == REQ) || (state_q == WAIT)),
        .complete      ((state_q == WAIT) && i_imem_rsp_valid),
        .pc            (pc),
        .kill          (kill)
    );

    // Fetch FSM next state and instruction capture. A redirect in IDLE takes
    // the cycle, so a simultaneous fetch command is not accepted.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fault_d = fault_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_fetch_valid && !i_redirect_valid) begin
                    if (pc[1:0] == 2'b00) begin
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                        fault_d = 1'b1;
                        data_d  = '0;
                    end
                end
            end
            REQ: begin
                if (i_imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (i_imem_rsp_valid) begin
                    if (kill || i_redirect_valid) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        data_d  = i_imem_rsp_data;
                        fault_d = i_imem_rsp_err;
                    end
                end
            end
            HOLD: begin
                if (i_redirect_valid) begin
                    state_d = IDLE;
                end else if (i_instr_ready) begin
                    state_d = IDLE;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                assert (1'b0) else $error("fetch_unit: illegal FSM state");
            end
        endcase
    end

    // State and captured-instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign o_fetch_ready    = (state_q == IDLE) && !i_redirect_valid;
    assign o_instr_valid    = (state_q == HOLD);
    assign o_imem_req_valid = (state_q == REQ);
    assign o_imem_addr      = pc;
    assign o_instr_pc       = pc;
    assign o_instr_data     = data_q;
    assign o_instr_fault    = fault_q;

endmodule
